// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-bit shift controller that steps an external one-bit shifter once per clock
//   clk, rst_n                    clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready             request handshake; in_data, in_op (00 SLL, 01 SRL, 11 SRA, 10 SLL), in_amt
//   out_valid/out_ready           result handshake; out_data, out_c (last bit out), out_zero
//   busy                          high whenever not idle
//   sh_a/sh_la/sh_lr, sh_y/sh_c   drive and result of the external combinational shifter
module shift_sequencer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_op,
    input  logic [CNT_W-1:0] in_amt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_c,
    output logic             out_zero,
    output logic             busy,
    output logic [WIDTH-1:0] sh_a,
    output logic             sh_la,
    output logic             sh_lr,
    input  logic [WIDTH-1:0] sh_y,
    input  logic             sh_c
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;
    state_e           state_q;
    logic [WIDTH-1:0] work_q;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       op_q;
    logic             carry_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             busy_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            work_q      <= '0;
            cnt_q       <= '0;
            op_q        <= '0;
            carry_q     <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    work_q      <= in_data;
                    op_q        <= in_op;
                    cnt_q       <= in_amt;
                    carry_q     <= 1'b0;
                    in_ready_q  <= 1'b0;
                    busy_q      <= 1'b1;
                    // a zero amount skips the shifter entirely
                    state_q     <= (in_amt != '0) ? SHIFT : DONE;
                    out_valid_q <= (in_amt == '0);
                end
                SHIFT: begin
                    work_q  <= sh_y;
                    carry_q <= sh_c;
                    cnt_q   <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: if (out_ready) begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    busy_q      <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign out_data  = work_q;
    assign out_c     = carry_q;
    assign out_zero  = (work_q == '0);
    assign sh_a      = work_q;
    assign sh_la     = op_q[1];
    assign sh_lr     = op_q[0];
endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: randomized and directed checks of shift_sequencer against an arithmetic shift model
module tb_shift_sequencer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = '0;
    logic [1:0] in_op = '0;
    logic [2:0] in_amt = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic       out_c;
    logic       out_zero;
    logic       busy;
    logic [7:0] sh_a;
    logic       sh_la;
    logic       sh_lr;
    logic [7:0] sh_y;
    logic       sh_c;
    int         tests = 0;
    int         fails = 0;
    int         acc_cnt = 0;

    shift_sequencer #(.WIDTH(8), .CNT_W(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_op(in_op), .in_amt(in_amt),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_c(out_c),
        .out_zero(out_zero), .busy(busy),
        .sh_a(sh_a), .sh_la(sh_la), .sh_lr(sh_lr), .sh_y(sh_y), .sh_c(sh_c)
    );

    always #5 clk = ~clk;

    // one-bit shifter that the sequencer drives
    assign sh_y = sh_lr ? {sh_la & sh_a[7], sh_a[7:1]} : {sh_a[6:0], 1'b0};
    assign sh_c = sh_lr ? sh_a[0] : sh_a[7];

    always @(posedge clk) if (in_valid && in_ready) acc_cnt++;

    function automatic void ref_shift(input logic [7:0] d, input logic [1:0] op, input int amt,
                                      output logic [7:0] y, output logic c);
        logic signed [7:0] s;
        s = d;
        if (amt == 0) begin
            y = d;
            c = 1'b0;
        end else if (!op[0]) begin
            y = 8'(d << amt);
            c = d[8-amt];
        end else begin
            y = op[1] ? 8'(s >>> amt) : 8'(d >> amt);
            c = d[amt-1];
        end
    endfunction

    task automatic do_op(input logic [7:0] d, input logic [1:0] op, input logic [2:0] amt, input int hold,
                         output logic [7:0] od, output logic oc, output logic oz, output int lat,
                         output logic sla, output logic slr, output logic stable);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        in_valid = 1'b1; in_data = d; in_op = op; in_amt = amt;
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_data = 8'($urandom); in_op = 2'($urandom); in_amt = 3'($urandom);
        lat = 0; sla = 1'b0; slr = 1'b0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1 && !out_valid) begin
                sla = sh_la;
                slr = sh_lr;
            end
        end while (!out_valid && lat < 40);
        od = out_data; oc = out_c; oz = out_zero; stable = 1'b1;
        repeat (hold) begin
            @(negedge clk);
            if (!out_valid || out_data !== od || out_c !== oc || in_ready) stable = 1'b0;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic test_reset;
        #12;
        tests++;
        if ({in_ready, out_valid, out_data, out_c, out_zero, busy, sh_a, sh_la, sh_lr} !==
            {1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL reset_state: rdy=%b vld=%b data=%h c=%b z=%b busy=%b sh_a=%h la=%b lr=%b, want 1 0 00 0 1 0 00 0 0",
                     in_ready, out_valid, out_data, out_c, out_zero, busy, sh_a, sh_la, sh_lr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed;
        logic [7:0] od;
        logic oc, oz, sla, slr, st;
        int lat;
        do_op(8'h81, 2'b00, 3'd1, 0, od, oc, oz, lat, sla, slr, st);
        tests++;
        if ({od, oc, oz} !== {8'h02, 1'b1, 1'b0} || lat !== 2) begin
            fails++;
            $display("FAIL sll_81_1: data=%h c=%b z=%b lat=%0d, want 02 1 0 lat 2", od, oc, oz, lat);
        end
        do_op(8'h80, 2'b11, 3'd3, 0, od, oc, oz, lat, sla, slr, st);
        tests++;
        if ({od, oc, oz} !== {8'hF0, 1'b0, 1'b0} || lat !== 4) begin
            fails++;
            $display("FAIL sra_80_3: data=%h c=%b z=%b lat=%0d, want f0 0 0 lat 4", od, oc, oz, lat);
        end
        tests++;
        if ({sla, slr} !== 2'b11) begin
            fails++;
            $display("FAIL sra_sh_ctrl: la=%b lr=%b, want 1 1", sla, slr);
        end
        do_op(8'h0F, 2'b01, 3'd4, 0, od, oc, oz, lat, sla, slr, st);
        tests++;
        if ({od, oc, oz} !== {8'h00, 1'b1, 1'b1} || lat !== 5) begin
            fails++;
            $display("FAIL srl_0f_4: data=%h c=%b z=%b lat=%0d, want 00 1 1 lat 5", od, oc, oz, lat);
        end
        tests++;
        if ({sla, slr} !== 2'b01) begin
            fails++;
            $display("FAIL srl_sh_ctrl: la=%b lr=%b, want 0 1", sla, slr);
        end
        do_op(8'hA5, 2'b11, 3'd0, 0, od, oc, oz, lat, sla, slr, st);
        tests++;
        if ({od, oc, oz} !== {8'hA5, 1'b0, 1'b0} || lat !== 1) begin
            fails++;
            $display("FAIL amt0_a5: data=%h c=%b z=%b lat=%0d, want a5 0 0 lat 1", od, oc, oz, lat);
        end
    endtask

    task automatic test_backpressure;
        int n;
        @(negedge clk);
        acc_cnt = 0;
        in_valid = 1'b1; in_data = 8'h3C; in_op = 2'b00; in_amt = 3'd2;
        @(posedge clk);
        #1;
        in_data = 8'hFF; in_op = 2'b01; in_amt = 3'd5;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 20);
        repeat (5) begin
            tests++;
            if ({out_valid, out_data, out_c, in_ready} !== {1'b1, 8'hF0, 1'b0, 1'b0}) begin
                fails++;
                $display("FAIL bp_hold: vld=%b data=%h c=%b rdy=%b, want 1 f0 0 0", out_valid, out_data, out_c, in_ready);
            end
            @(negedge clk);
        end
        tests++;
        if (acc_cnt !== 1) begin
            fails++;
            $display("FAIL bp_accepts_held: accepts=%0d, want 1", acc_cnt);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (acc_cnt !== 2) begin
            fails++;
            $display("FAIL bp_accepts_after: accepts=%0d, want 2", acc_cnt);
        end
        tests++;
        if ({out_valid, out_data, out_c, out_zero} !== {1'b1, 8'h07, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL bp_second: vld=%b data=%h c=%b z=%b, want 1 07 1 0", out_valid, out_data, out_c, out_zero);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid;
        logic seen;
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'hC3; in_op = 2'b10; in_amt = 3'd7;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL mid_busy: busy=%b vld=%b, want 1 0", busy, out_valid);
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if ({in_ready, out_valid, out_data, out_c, out_zero, busy, sh_a, sh_la, sh_lr} !==
            {1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL mid_reset: rdy=%b vld=%b data=%h c=%b z=%b busy=%b sh_a=%h la=%b lr=%b, want 1 0 00 0 1 0 00 0 0",
                     in_ready, out_valid, out_data, out_c, out_zero, busy, sh_a, sh_la, sh_lr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            seen |= out_valid;
        end
        tests++;
        if (seen !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL mid_no_result: seen_valid=%b rdy=%b, want 0 1", seen, in_ready);
        end
    endtask

    task automatic test_random;
        logic [7:0] d, od, ey;
        logic [1:0] op;
        logic [2:0] amt;
        logic oc, oz, sla, slr, st, ec;
        int lat;
        for (int i = 0; i < 40; i++) begin
            d = 8'($urandom);
            op = 2'($urandom);
            amt = 3'($urandom);
            ref_shift(d, op, int'(amt), ey, ec);
            do_op(d, op, amt, int'($urandom_range(0, 3)), od, oc, oz, lat, sla, slr, st);
            tests++;
            if ({od, oc, oz} !== {ey, ec, ey == 8'h00}) begin
                fails++;
                $display("FAIL rand_result[%0d] d=%h op=%b amt=%0d: got %h c=%b z=%b, want %h c=%b z=%b",
                         i, d, op, amt, od, oc, oz, ey, ec, ey == 8'h00);
            end
            tests++;
            if (lat !== int'(amt) + 1) begin
                fails++;
                $display("FAIL rand_latency[%0d]: got %0d, want %0d", i, lat, int'(amt) + 1);
            end
            tests++;
            if (st !== 1'b1) begin
                fails++;
                $display("FAIL rand_stable[%0d]: got %b, want 1", i, st);
            end
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_backpressure;
        test_reset_mid;
        test_random;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
